// File: rtl/sag_seq.sv
// sag_seq: sequential PEXT / PDEP / SAG unit on 8-bit operands.
// Bits move through a three-stage shift network, one stage per cycle.
// Each live bit carries a 3-bit tag holding its total move distance.
// PEXT moves bits down by 1, 2, 4; PDEP moves them up by 4, 2, 1.
// SAG runs the PEXT pass twice (mask ci, then ~ci) and merges the halves.
module sag_seq (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_di,
    input  logic [7:0] in_ci,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic       busy,
    output logic [7:0] done_count
);
    typedef enum logic [2:0] {IDLE, DECODE, STAGE, MERGE, DONE} state_t;

    localparam logic [1:0] OP_PDEP = 2'd1;
    localparam logic [1:0] OP_SAG  = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;

    state_t          state_q;
    logic            in_ready_q, busy_q, out_valid_q, out_err_q;
    logic [7:0]      out_data_q, done_cnt_q;
    logic [1:0]      op_q;
    logic [7:0]      di_q, ci_q;
    logic            pass_q;      // 0: first pass (mask ci), 1: SAG second pass (mask ~ci)
    logic [1:0]      stg_q;       // index of the next shift stage, 0..2
    logic [7:0]      dat_q, vld_q;
    logic [7:0][2:0] tag_q;       // remaining move distance of the bit at each position
    logic [7:0]      res1_q;      // SAG first-pass result
    logic [3:0]      pop_q;       // popcount(ci), the SAG merge boundary

    // Decoder: prefix popcount of the active mask, move distances, initial layout
    logic [7:0]      mask;
    logic [3:0]      pc [9];
    logic [7:0][2:0] zdist;
    logic [7:0][2:0] dep_tag;
    logic [7:0]      dep_vld;
    logic [7:0]      dec_dat, dec_vld;
    logic [7:0][2:0] dec_tag;
    logic            is_dep;

    assign is_dep = (op_q == OP_PDEP);
    assign mask   = pass_q ? ~ci_q : ci_q;
    assign pc[0]  = 4'd0;

    genvar gi, gb;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign pc[gi+1]   = pc[gi] + {3'b000, mask[gi]};
            // zeros of the mask below bit gi = distance that bit travels
            assign zdist[gi]  = 3'(gi) - pc[gi][2:0];
            assign dep_vld[gi] = (4'(gi) < pc[8]);
        end
    endgenerate

    // For PDEP the bit of rank j starts at position j, tagged with its destination's distance
    always_comb begin
        dep_tag = '0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i] && (pc[i] == 4'(j))) begin
                    dep_tag[j] = dep_tag[j] | zdist[i];
                end
            end
        end
    end

    assign dec_vld = is_dep ? dep_vld : mask;
    assign dec_dat = is_dep ? (di_q & dep_vld) : (di_q & mask);
    assign dec_tag = is_dep ? dep_tag : zdist;

    // Shift network: for each stage distance, a down (PEXT) and an up (PDEP) variant
    logic [2:0][7:0]      dn_dat, dn_vld, up_dat, up_vld;
    logic [2:0][7:0][2:0] dn_tag, up_tag;

    generate
        for (gb = 0; gb < 3; gb++) begin : g_stage
            localparam int D = 1 << gb;
            for (gi = 0; gi < 8; gi++) begin : g_bit
                logic dn_take, up_take, keep;
                logic dn_sd, up_sd;
                logic [2:0] dn_st, up_st;
                // a bit stays put when its swap control for this stage is clear
                assign keep = vld_q[gi] & ~tag_q[gi][gb];
                if (gi + D < 8) begin : g_hi
                    assign dn_take = vld_q[gi+D] & tag_q[gi+D][gb];
                    assign dn_sd   = dat_q[gi+D];
                    assign dn_st   = tag_q[gi+D];
                end else begin : g_nohi
                    assign dn_take = 1'b0;
                    assign dn_sd   = 1'b0;
                    assign dn_st   = 3'd0;
                end
                if (gi - D >= 0) begin : g_lo
                    assign up_take = vld_q[gi-D] & tag_q[gi-D][gb];
                    assign up_sd   = dat_q[gi-D];
                    assign up_st   = tag_q[gi-D];
                end else begin : g_nolo
                    assign up_take = 1'b0;
                    assign up_sd   = 1'b0;
                    assign up_st   = 3'd0;
                end
                assign dn_vld[gb][gi] = dn_take | keep;
                assign dn_dat[gb][gi] = dn_take ? dn_sd : (keep & dat_q[gi]);
                assign dn_tag[gb][gi] = dn_take ? dn_st : (keep ? tag_q[gi] : 3'd0);
                assign up_vld[gb][gi] = up_take | keep;
                assign up_dat[gb][gi] = up_take ? up_sd : (keep & dat_q[gi]);
                assign up_tag[gb][gi] = up_take ? up_st : (keep ? tag_q[gi] : 3'd0);
            end
        end
    endgenerate

    logic [1:0]      up_sel;
    logic [7:0]      stg_dat_d, stg_vld_d;
    logic [7:0][2:0] stg_tag_d;
    logic [15:0]     merge_hi;

    assign up_sel    = 2'd2 - stg_q;
    assign stg_dat_d = is_dep ? up_dat[up_sel] : dn_dat[stg_q];
    assign stg_vld_d = is_dep ? up_vld[up_sel] : dn_vld[stg_q];
    assign stg_tag_d = is_dep ? up_tag[up_sel] : dn_tag[stg_q];
    // p = 0 or 8 must not wrap, so shift in a 16-bit field and keep the low byte
    assign merge_hi  = {8'h00, dat_q} << pop_q;

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_err_q   <= 1'b0;
            done_cnt_q  <= 8'h00;
            op_q        <= 2'd0;
            di_q        <= 8'h00;
            ci_q        <= 8'h00;
            pass_q      <= 1'b0;
            stg_q       <= 2'd0;
            dat_q       <= 8'h00;
            vld_q       <= 8'h00;
            tag_q       <= '0;
            res1_q      <= 8'h00;
            pop_q       <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= in_op;
                        di_q       <= in_di;
                        ci_q       <= in_ci;
                        pass_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_op == OP_RSV) begin
                            out_data_q <= 8'h00;
                            out_err_q  <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q    <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    dat_q <= dec_dat;
                    vld_q <= dec_vld;
                    tag_q <= dec_tag;
                    stg_q <= 2'd0;
                    if (!pass_q) begin
                        pop_q <= pc[8];
                    end
                    state_q <= STAGE;
                end
                STAGE: begin
                    dat_q <= stg_dat_d;
                    vld_q <= stg_vld_d;
                    tag_q <= stg_tag_d;
                    if (stg_q == 2'd2) begin
                        if (op_q == OP_SAG) begin
                            if (!pass_q) begin
                                res1_q  <= stg_dat_d;
                                pass_q  <= 1'b1;
                                state_q <= DECODE;
                            end else begin
                                state_q <= MERGE;
                            end
                        end else begin
                            out_data_q  <= is_dep ? (stg_dat_d & ci_q) : stg_dat_d;
                            out_err_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        stg_q <= stg_q + 2'd1;
                    end
                end
                MERGE: begin
                    out_data_q  <= res1_q | merge_hi[7:0];
                    out_err_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        // reserved op arrives here with valid low; present it one cycle later
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 8'd1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign done_count = done_cnt_q;

endmodule

// File: tb/tb_sag_seq.sv
// Testbench for sag_seq: scoreboard of expected results pushed at accept,
// popped and compared when the result handshake occurs.
module tb_sag_seq;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'd0;
    logic [7:0] in_di = 8'h00;
    logic [7:0] in_ci = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;
    logic       busy;
    logic [7:0] done_count;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_done = 8'h00;

    sag_seq dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_di      (in_di),
        .in_ci      (in_ci),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clock = ~clock;

    // in_ready and busy must always be complements of each other
    always @(negedge clock) begin
        checks++;
        if (in_ready === busy) begin
            errors++;
            $display("FAIL ready_vs_busy: in_ready=%b busy=%b required opposite", in_ready, busy);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] f_pext(input logic [7:0] d, input logic [7:0] m);
        logic [7:0] r;
        int k;
        r = 8'h00;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                r = r | (((d >> i) & 8'h01) << k);
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] f_pdep(input logic [7:0] d, input logic [7:0] m);
        logic [7:0] r;
        int k;
        r = 8'h00;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                r = r | (((d >> k) & 8'h01) << i);
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d, input logic [7:0] m);
        logic [15:0] t;
        int p;
        case (op)
            2'd0: return f_pext(d, m);
            2'd1: return f_pdep(d, m);
            2'd2: begin
                p = $countones(m);
                t = {8'h00, f_pext(d, ~m)} << p;
                return f_pext(d, m) | t[7:0];
            end
            default: return 8'h00;
        endcase
    endfunction

    // One full transaction: accept, latency, optional backpressure, result, handshake
    task automatic run_op(input logic [1:0] op, input logic [7:0] di, input logic [7:0] ci,
                          input int hold, input bit junk);
        int         w;
        int         lat;
        int         exp_lat;
        logic [8:0] exp_v;
        logic [7:0] held;
        exp_lat = (op == 2'd3) ? 1 : ((op == 2'd2) ? 9 : 4);
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clock); #1; w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
            return;
        end
        in_valid = 1'b1; in_op = op; in_di = di; in_ci = ci;
        @(posedge clock); #1;
        exp_q.push_back({(op == 2'd3), model(op, di, ci)});
        if (junk) begin
            in_op = 2'($urandom_range(0, 3)); in_di = 8'($urandom); in_ci = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(posedge clock); #1; lat++;
            if (junk) begin
                in_op = 2'($urandom_range(0, 3)); in_di = 8'($urandom); in_ci = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency op=%0d di=%h ci=%h: got %0d cycles required %0d", op, di, ci, lat, exp_lat);
        end
        if (out_valid !== 1'b1) begin
            void'(exp_q.pop_front());
            return;
        end
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold: valid=%b data=%h ready=%b busy=%b required 1 %h 0 1",
                         out_valid, out_data, in_ready, busy, held);
            end
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (out_data !== exp_v[7:0]) begin
            errors++;
            $display("FAIL data op=%0d di=%h ci=%h: got %h required %h", op, di, ci, out_data, exp_v[7:0]);
        end
        checks++;
        if (out_err !== exp_v[8]) begin
            errors++;
            $display("FAIL err op=%0d: got %b required %b", op, out_err, exp_v[8]);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        exp_done = exp_done + 8'd1;
        checks++;
        if (done_count !== exp_done) begin
            errors++;
            $display("FAIL done_count: got %h required %h", done_count, exp_done);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        $display("op=%0d di=%h ci=%h -> data=%h err=%b lat=%0d done=%h", op, di, ci, out_data, out_err, lat, done_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 ||
            busy !== 1'b0 || done_count !== 8'h00) begin
            errors++;
            $display("FAIL %s: ready=%b valid=%b data=%h err=%b busy=%b cnt=%h required 1 0 00 0 0 00",
                     tag, in_ready, out_valid, out_data, out_err, busy, done_count);
        end
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        #2;
        check_reset_outputs("reset_values");
        exp_done = 8'h00;
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        in_valid = 1'b1; in_op = 2'd0; in_di = 8'hFF; in_ci = 8'hFF;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_hold");
        in_valid = 1'b0;
        resetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic;
        run_op(2'd0, 8'hB5, 8'hF0, 0, 1'b0);
        run_op(2'd1, 8'h0B, 8'hF0, 0, 1'b0);
        run_op(2'd2, 8'hB5, 8'hAA, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_op(2'd0, 8'hFF, 8'h0F, 5, 1'b0);
    endtask

    task automatic test_reserved;
        run_op(2'd3, 8'hA5, 8'h3C, 0, 1'b0);
        run_op(2'd3, 8'hFF, 8'hFF, 2, 1'b0);
    endtask

    task automatic test_mask_bounds;
        run_op(2'd0, 8'hA7, 8'h00, 0, 1'b0);
        run_op(2'd1, 8'hA7, 8'h00, 0, 1'b0);
        run_op(2'd0, 8'h5A, 8'hFF, 0, 1'b0);
        run_op(2'd1, 8'h5A, 8'hFF, 0, 1'b0);
        run_op(2'd2, 8'h5A, 8'hFF, 0, 1'b0);
        run_op(2'd2, 8'h5A, 8'h00, 0, 1'b0);
    endtask

    task automatic test_ignore_busy;
        run_op(2'd2, 8'hC3, 8'h69, 0, 1'b1);
        run_op(2'd1, 8'h2D, 8'hB4, 0, 1'b1);
    endtask

    task automatic test_reset_midop;
        in_valid = 1'b1; in_op = 2'd1; in_di = 8'h0B; in_ci = 8'hF0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: got %b required 1", busy);
        end
        resetn = 1'b0;
        #1;
        check_reset_outputs("midop_abort");
        exp_done = 8'h00;
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
        $display("mid-operation reset applied");
        run_op(2'd0, 8'hB5, 8'hF0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0, 1'b0);
        end
        checks++;
        if (done_count !== 8'h00) begin
            errors++;
            $display("FAIL done_wrap: got %h required 00", done_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reserved();
        test_mask_bounds();
        test_ignore_busy();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
